// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider sequencer.
//   state_t     : FSM encodings (IDLE/BUSY/DONE)
//   WIDTH_DEF   : default operand/result width
//   CNT_W_DEF   : default iteration counter width (2^CNT_W > WIDTH)
//   DIVZERO_LO  : quotient returned for a zero divisor (all ones)
package div_ctrl_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH_DEF-1:0] DIVZERO_LO = '1;
endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider bus.
//   master : EX side (drives request, flush, EX hold; observes stall/result)
//   slave  : divider side
interface div_ctrl_if import div_ctrl_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             ex_stall_i;
  logic             stall_div_o;
  logic             result_valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, a_i, b_i, cancel_i, ex_stall_i,
    input  stall_div_o, result_valid_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, cancel_i, ex_stall_i,
    output stall_div_o, result_valid_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration (combinational).
//   rq     : current {remainder, quotient}
//   dvsr   : divisor magnitude
//   rq_nxt : {remainder, quotient} after shift + trial subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq,
  input  logic [WIDTH-1:0]   dvsr,
  output logic [2*WIDTH-1:0] rq_nxt
);
  logic [WIDTH:0] sh, diff;

  // rem < dvsr always holds, so the shifted remainder is < 2*dvsr and
  // diff[WIDTH] is exactly the borrow of the trial subtraction.
  always_comb begin
    sh     = rq[2*WIDTH-1:WIDTH-1];
    diff   = sh - {1'b0, dvsr};
    rq_nxt = {sh[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) rq_nxt = {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer feeding HILO: one restoring iteration per cycle,
// stalls F/D/E while busy, holds the result until EX advances.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : start/signed/a/b/cancel/ex_stall in,
//                 stall_div/result_valid/hi(rem)/lo(quot) out
module div_ctrl import div_ctrl_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic       clk,
  input logic       resetn,
  div_ctrl_if.slave bus
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, dvsr, hi, lo;
  logic             q_neg, r_neg;
  logic             go, fin;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b, rem_n, quot_n;
  logic [2*WIDTH-1:0] rq_nxt;

  assign a_neg  = bus.signed_i & bus.a_i[WIDTH-1];
  assign b_neg  = bus.signed_i & bus.b_i[WIDTH-1];
  assign abs_a  = a_neg ? -bus.a_i : bus.a_i;
  assign abs_b  = b_neg ? -bus.b_i : bus.b_i;
  assign b_zero = (bus.b_i == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq     ({rem, quot}),
    .dvsr   (dvsr),
    .rq_nxt (rq_nxt)
  );

  assign rem_n  = rq_nxt[2*WIDTH-1:WIDTH];
  assign quot_n = rq_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (bus.start_i && !bus.cancel_i) begin
        go        = 1'b1;
        state_nxt = b_zero ? DONE : BUSY;
      end
      BUSY: if (cnt == CNT_W'(WIDTH-1)) begin
        fin       = !bus.cancel_i;
        state_nxt = DONE;
      end
      DONE: if (!bus.ex_stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.cancel_i) state_nxt = IDLE;
  end

  // Gated by resetn so the hazard unit never sees a stall while in reset.
  assign bus.stall_div_o = resetn & !bus.cancel_i &
                           (((state == IDLE) & bus.start_i) | (state == BUSY));
  assign bus.result_valid_o = (state == DONE);
  assign bus.hi_o = hi;
  assign bus.lo_o = lo;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt   <= '0;
      rem   <= '0;
      quot  <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (go) begin
      cnt   <= '0;
      rem   <= '0;
      quot  <= abs_a;
      dvsr  <= abs_b;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      // Zero divisor skips iteration: raw dividend as remainder.
      if (b_zero) begin
        hi <= bus.a_i;
        lo <= WIDTH'(signed'(DIVZERO_LO));
      end
    end else if (state == BUSY && !bus.cancel_i) begin
      cnt  <= cnt + CNT_W'(1);
      rem  <= rem_n;
      quot <= quot_n;
      // Negating a zero remainder yields zero, so no special case needed.
      if (fin) begin
        hi <= r_neg ? -rem_n  : rem_n;
        lo <= q_neg ? -quot_n : quot_n;
      end
    end
  end
endmodule
